// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: FSM state encoding,
// opcode/funct values, alucontrol codes and the per-state registered control word.
// No ports; imported by mips_alu_dec and mips_mc_control.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // alucontrol codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop: how the ALU decoder should pick alucontrol
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Control outputs that depend only on the state. They are registered from the
  // next state so they come straight off flops in the cycle the state is entered.
  typedef struct packed {
    logic       jump_pcen;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      ST_FETCH:   c.alusrcb = 2'b01;
      ST_DECODE:  c.alusrcb = 2'b11;
      ST_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ST_MEMRD:   c.iord = 1'b1;
      ST_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      ST_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      ST_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      ST_BRANCH: begin
        c.alusrca = 1'b1;
        c.pcsrc   = 2'b01;
        c.aluop   = ALUOP_SUB;
      end
      ST_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ST_ADDIWB:  c.regwrite = 1'b1;
      ST_JUMP: begin
        c.pcsrc     = 2'b10;
        c.jump_pcen = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic funct_legal(logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU decoder: maps aluop and the R-type funct field to a 3-bit alucontrol code.
// Purely combinational, zero latency, no flow control.
// Ports: aluop[1:0], funct[5:0] in; alucontrol[2:0] out.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM (lw/sw/R-type/beq/bne/addi/j) driving datapath enables and selects.
// Latency with mem_ready=1: lw 5, sw/R/addi 4, branch/j 3, illegal 2 cycles.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0.
// Ports: clk, rst_n (async, active-low); op/funct from IR; zero/neg ALU flags;
// mem_ready; write enables pcen/irwrite/memwrite/regwrite; selects iord/regdst/
// memtoreg/alusrca/alusrcb/pcsrc; alucontrol; illegal (one-cycle pulse).
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int SUPPORT_BNE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  localparam logic BNE_EN = (SUPPORT_BNE != 0);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  // The N flag has no consumer in this revision.
  logic unused_neg;
  assign unused_neg = neg;

  // Next-state logic. op/funct are stable from DECODE onward because the IR
  // only loads during FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = funct_legal(funct) ? ST_EXECUTE : ST_FETCH;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_BNE:       state_d = BNE_EN ? ST_BRANCH : ST_FETCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:   state_d = ST_FETCH;
      ST_MEMWR:   if (mem_ready) state_d = ST_FETCH;
      ST_EXECUTE: state_d = ST_ALUWB;
      ST_ALUWB:   state_d = ST_FETCH;
      ST_BRANCH:  state_d = ST_FETCH;
      ST_ADDIEX:  state_d = ST_ADDIWB;
      ST_ADDIWB:  state_d = ST_FETCH;
      ST_JUMP:    state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  // State and registered Moore outputs. Reset loads the FETCH control word so
  // the selects already read as a fetch while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ctrl_q  <= state_ctrl(ST_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  logic in_fetch, in_branch, br_take;
  assign in_fetch  = (state_q == ST_FETCH);
  assign in_branch = (state_q == ST_BRANCH);
  // bne only reaches BRANCH when it is enabled, so op alone picks the sense.
  assign br_take   = (op == OP_BNE) ? ~zero : zero;

  // The mem_ready/zero-dependent enables are combinational; gating them with
  // rst_n keeps every write enable low for as long as reset is held.
  assign irwrite  = rst_n & in_fetch & mem_ready;
  assign pcen     = rst_n & ((in_fetch & mem_ready) | (in_branch & br_take) |
                             ctrl_q.jump_pcen);
  // DECODE falling back to FETCH is exactly the undecodable-instruction case.
  assign illegal  = rst_n & (state_q == ST_DECODE) & (state_d == ST_FETCH);

  assign memwrite = ctrl_q.memwrite;
  assign regwrite = ctrl_q.regwrite;
  assign iord     = ctrl_q.iord;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;

  mips_alu_dec u_alu_dec (
    .aluop      (ctrl_q.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have parameter SUPPORT_BNE, default 1, meaning bne (op 000101) is decoded; when 0, bne is treated as illegal.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports op and funct, input, 6 each, opcode and function fields of the instruction register.
REQ-005 SHALL have ports zero and neg, input, 1 each, the ALU Z and N flags of the current cycle.
REQ-006 SHALL have port mem_ready, input, 1, memory access completes in the cycle it is high.
REQ-007 SHALL have write-enable ports pcen, irwrite, memwrite and regwrite, output, 1 each.
REQ-008 SHALL have mux-select ports iord, regdst, memtoreg and alusrca, output, 1 each.
REQ-009 SHALL have ports alusrcb and pcsrc, output, 2 each, the ALU B select and the PC source select.
REQ-010 SHALL have port alucontrol, output, 3, with codes 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-011 SHALL have port illegal, output, 1, a one-cycle pulse on an undecodable instruction.

Function
REQ-012 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-013 Unlisted outputs SHALL be 0 in every state, and alucontrol SHALL be 010 except in EXECUTE and BRANCH.
REQ-014 FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00; irwrite and pcen = mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-015 DECODE: alusrca=0, alusrcb=11 (branch target), ADD; next state by op:
  - lw 100011 and sw 101011 -> MEMADR
  - R-type 000000 -> EXECUTE
  - beq 000100 and bne 000101 -> BRANCH
  - addi 001000 -> ADDIEX
  - j 000010 -> JUMP
REQ-016 DECODE with any other op, or R-type with funct not in {100000, 100010, 100100, 100101, 101010}, SHALL pulse illegal for one cycle and return to FETCH with no write enable asserted.
REQ-017 MEMADR: alusrca=1, alusrcb=10, ADD; next MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD: iord=1; hold in MEMRD while mem_ready=0, then go to MEMWB.
REQ-019 MEMWB: regdst=0, memtoreg=1, regwrite=1; then go to FETCH.
REQ-020 MEMWR: iord=1, memwrite=1, held high continuously until mem_ready=1; then go to FETCH.
REQ-021 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (add 010, sub 110, and 000, or 001, slt 111); then go to ALUWB.
REQ-022 ALUWB: regdst=1, memtoreg=0, regwrite=1; then go to FETCH.
REQ-023 BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01; pcen = zero for beq and ~zero for bne (combinational on zero); then go to FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, ADD; then ADDIWB, which asserts regdst=0, memtoreg=0, regwrite=1; then go to FETCH.
REQ-025 JUMP: pcsrc=10, pcen=1; then go to FETCH.
REQ-026 With mem_ready=1, instruction latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles; illegal 2 cycles.
REQ-027 neg SHALL be ignored by this revision and SHALL NOT affect any output.

Reset
REQ-028 rst_n low SHALL immediately force state to FETCH and all write enables (pcen, irwrite, memwrite, regwrite) and illegal to 0, regardless of clk.
REQ-029 Reset asserted mid-instruction, including a MEMWR stall, SHALL abort the instruction; the first FETCH cycle after rst_n rises SHALL be a normal fetch.

Structure
REQ-030 State encodings, opcode/funct constants and alucontrol codes SHALL live in shared package mips_ctrl_pkg.
REQ-031 Funct-to-alucontrol decode SHALL be a combinational sub-module mips_alu_dec (inputs aluop[1:0] and funct, output alucontrol), instantiated once.

Verification
REQ-032 lw (op 100011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 in cycle 5 only.
REQ-033 sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH.
REQ-034 R-type slt (funct 101010) -> alucontrol=111 in EXECUTE, regwrite=1 with regdst=1 in ALUWB.
REQ-035 beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; bne with zero=1 -> pcen=0.
REQ-036 op 111111 -> illegal=1 for exactly one cycle, no write enable asserted, next state FETCH.
REQ-037 rst_n driven low mid-MEMWR between clock edges -> memwrite=0 immediately; after release, FETCH asserts irwrite=1 when mem_ready=1.
